// File: rtl/fifo_rr_sched.sv
`default_nettype none
// ============================================================================
// fifo_rr_sched: round-robin scheduler that pops up to MAXBURST entries per
// grant from NREQ requester FIFOs into one registered output stage.
// Revision: 1.0
// ============================================================================
module fifo_rr_sched #(
  parameter  int NREQ     = 4,
  parameter  int WIDTH    = 4,
  parameter  int MAXBURST = 4,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW       = $clog2(MAXBURST + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_dat,
  input  logic [NREQ-1:0]             req_val,
  input  logic [NREQ-1:0]             req_en,
  output logic [NREQ-1:0]             req_pop,
  output logic [WIDTH-1:0]            out_dat,
  output logic [IW-1:0]               out_src,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic                        busy,
  output logic [IW-1:0]               gnt_id
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_gnt_id;
  logic [BW-1:0]   r_burst_cnt;

  logic [IW:0]     w_idx;
  logic [IW-1:0]   w_sel;
  logic            w_any;
  logic            w_gnt_ok;
  logic            w_out_free;
  logic            w_pop;
  logic            w_last;
  logic            w_exit;
  logic [IW-1:0]   w_next_ptr;

  // Rotating priority search starting at r_rr_ptr; w_idx carries one spare
  // bit so the modulo wrap works for non-power-of-two NREQ.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) begin
        w_idx = w_idx - (IW+1)'(NREQ);
      end
      if (!w_any && req_val[w_idx[IW-1:0]] && req_en[w_idx[IW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[IW-1:0];
      end
    end
  end

  assign w_gnt_ok   = req_val[r_gnt_id] & req_en[r_gnt_id];
  assign w_out_free = !out_val | out_rdy;
  assign w_pop      = (r_state == GRANT) & w_gnt_ok & w_out_free;
  assign w_last     = (r_burst_cnt == BW'(MAXBURST - 1));
  // A stalled consumer keeps the grant; only burst end or loss of the head does not.
  assign w_exit     = (w_pop & w_last) | !w_gnt_ok;
  assign w_next_ptr = (r_gnt_id == IW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;

  always_comb begin
    req_pop = '0;
    if (w_pop) begin
      req_pop[r_gnt_id] = 1'b1;
    end
  end

  assign gnt_id = r_gnt_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_burst_cnt <= '0;
      busy        <= 1'b0;
      out_dat     <= '0;
      out_src     <= '0;
      out_val     <= 1'b0;
    end else begin
      if (w_pop) begin
        out_dat <= req_dat[r_gnt_id];
        out_src <= r_gnt_id;
        out_val <= 1'b1;
      end else if (out_val && out_rdy) begin
        out_val <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_id    <= w_sel;
            r_burst_cnt <= '0;
            r_state     <= GRANT;
            busy        <= 1'b1;
          end
        end
        GRANT: begin
          if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
          if (w_exit) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
            busy     <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
